// File: rtl/bcd_7seg_scan_pkg.sv
// Shared seven-segment definitions: active-low gfedcba patterns, digit-slot encoding
// and the captured-value record used by multiplexed display blocks.
package bcd_7seg_scan_pkg;

   typedef enum logic [1:0] {
      DigUnits    = 2'd0,
      DigTens     = 2'd1,
      DigHundreds = 2'd2,
      DigSign     = 2'd3
   } digit_e;

   typedef struct packed {
      logic [3:0] centena;
      logic [3:0] dezena;
      logic [3:0] unidade;
      logic       negative;
   } digits_t;

   // negative=1 means non-negative, so the reset value shows no minus sign
   localparam digits_t DIGITS_RST = '{centena: 4'd0, dezena: 4'd0, unidade: 4'd0,
                                      negative: 1'b1};

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF = 4'b1111;

   function automatic logic [3:0] anode_mask(input digit_e d);
      logic [3:0] m;
      m = AN_OFF;
      unique case (d)
         DigUnits:    m = 4'b1110;
         DigTens:     m = 4'b1101;
         DigHundreds: m = 4'b1011;
         DigSign:     m = 4'b0111;
      endcase
      return m;
   endfunction

   function automatic digit_e next_digit(input digit_e d);
      digit_e n;
      n = DigUnits;
      unique case (d)
         DigUnits:    n = DigTens;
         DigTens:     n = DigHundreds;
         DigHundreds: n = DigSign;
         DigSign:     n = DigUnits;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; codes 10..15 show 'E'.
module bcd_to_seg
   import bcd_7seg_scan_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_E;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Four-digit multiplexed common-anode driver for sign/hundreds/tens/units with
// double-buffered input capture, per-slot de-ghosting guard and leading-zero blanking.
module bcd_7seg_scan
   import bcd_7seg_scan_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] centena,
   input  logic [3:0] dezena,
   input  logic [3:0] unidade,
   input  logic       negative,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame_done
);

   localparam int unsigned PW = $clog2(REFRESH_DIV);
   typedef logic [PW-1:0] pre_t;
   localparam pre_t PRE_LAST  = pre_t'(REFRESH_DIV - 1);
   localparam pre_t PRE_GUARD = pre_t'(GUARD);

   pre_t    pre_q;
   digit_e  idx_q;
   digits_t shadow_q;
   digits_t disp_q;
   digits_t in_digits;

   logic       term;
   logic       wrap;
   logic [3:0] sel_nib;
   logic       sel_blank;
   logic [6:0] dec_seg;
   logic [6:0] seg_next;
   logic [3:0] an_next;

   always_comb begin
      term      = (pre_q == PRE_LAST);
      wrap      = term && (idx_q == DigSign);
      in_digits = '{centena: centena, dezena: dezena, unidade: unidade, negative: negative};
   end

   // Blanking checks the displayed nibbles for exact zero, so 10..15 still show 'E'
   always_comb begin
      sel_nib   = disp_q.unidade;
      sel_blank = 1'b0;
      unique case (idx_q)
         DigUnits: sel_nib = disp_q.unidade;
         DigTens: begin
            sel_nib   = disp_q.dezena;
            sel_blank = blank_lz && (disp_q.centena == 4'd0) && (disp_q.dezena == 4'd0);
         end
         DigHundreds: begin
            sel_nib   = disp_q.centena;
            sel_blank = blank_lz && (disp_q.centena == 4'd0);
         end
         DigSign: begin
            sel_nib   = disp_q.unidade;
            sel_blank = disp_q.negative;
         end
      endcase
   end

   bcd_to_seg u_dec (
      .nib (sel_nib),
      .seg (dec_seg)
   );

   always_comb begin
      if (pre_q < PRE_GUARD) begin
         an_next  = AN_OFF;
         seg_next = SEG_BLANK;
      end else begin
         an_next = anode_mask(idx_q);
         if (sel_blank) begin
            seg_next = SEG_BLANK;
         end else if (idx_q == DigSign) begin
            seg_next = SEG_MINUS;
         end else begin
            seg_next = dec_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q      <= '0;
         idx_q      <= DigUnits;
         shadow_q   <= DIGITS_RST;
         disp_q     <= DIGITS_RST;
         an         <= AN_OFF;
         seg        <= SEG_BLANK;
         frame_done <= 1'b0;
      end else begin
         if (term) begin
            pre_q <= '0;
            idx_q <= next_digit(idx_q);
         end else begin
            pre_q <= pre_q + pre_t'(1);
         end
         if (load) begin
            shadow_q <= in_digits;
         end
         // A load coinciding with the wrap bypasses shadow so it is not lost for a frame
         if (wrap) begin
            disp_q <= load ? in_digits : shadow_q;
         end
         frame_done <= wrap;
         an         <= an_next;
         seg        <= seg_next;
      end
   end

endmodule
